// File: rtl/morse_pkg.sv
// Shared types, command constants and the Morse pattern decoder used by the
// character sequencer and its command FIFO.
package morse_pkg;

  localparam int MAX_SYM = 6;

  typedef enum logic [1:0] {
    CMD_CHAR    = 2'd0,
    CMD_NEWLINE = 2'd1,
    CMD_CLEAR   = 2'd2
  } cmd_kind_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEP  = 2'd1,
    S_WRAP = 2'd2
  } sched_state_t;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_NL      = 8'h0A;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  // bits holds the pattern right-aligned, first symbol most significant,
  // dot=0 dash=1; anything outside A-Z / 0-9 maps to '?'.
  function automatic logic [7:0] morse_decode(input logic [2:0] len,
                                              input logic [MAX_SYM-1:0] bits);
    logic [7:0] c;
    c = ASCII_UNKNOWN;
    case (len)
      3'd1: c = bits[0] ? "T" : "E";
      3'd2:
        case (bits[1:0])
          2'b00: c = "I";
          2'b01: c = "A";
          2'b10: c = "N";
          default: c = "M";
        endcase
      3'd3:
        case (bits[2:0])
          3'b000: c = "S";
          3'b001: c = "U";
          3'b010: c = "R";
          3'b011: c = "W";
          3'b100: c = "D";
          3'b101: c = "K";
          3'b110: c = "G";
          default: c = "O";
        endcase
      3'd4:
        case (bits[3:0])
          4'b0000: c = "H";
          4'b0001: c = "V";
          4'b0010: c = "F";
          4'b0100: c = "L";
          4'b0110: c = "P";
          4'b0111: c = "J";
          4'b1000: c = "B";
          4'b1001: c = "X";
          4'b1010: c = "C";
          4'b1011: c = "Y";
          4'b1100: c = "Z";
          4'b1101: c = "Q";
          default: c = ASCII_UNKNOWN;
        endcase
      3'd5:
        case (bits[4:0])
          5'b11111: c = "0";
          5'b01111: c = "1";
          5'b00111: c = "2";
          5'b00011: c = "3";
          5'b00001: c = "4";
          5'b00000: c = "5";
          5'b10000: c = "6";
          5'b11000: c = "7";
          5'b11100: c = "8";
          5'b11110: c = "9";
          default:  c = ASCII_UNKNOWN;
        endcase
      default: c = ASCII_UNKNOWN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/morse_char_sequencer_fifo.sv
// First-word-fall-through command FIFO; a flush may coincide with a push,
// in which case the pushed entry becomes the only one left.
module morse_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? ONE : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (flush & push)
      mem[0] <= push_data;
    else if (!flush && do_push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/morse_char_sequencer.sv
// Turns classified Morse pulses into CHAR / NEWLINE / CLEAR display commands
// and queues them for the display writer.
//
// state  | meaning
// S_IDLE | accepting gaps; letters and direct separators are pushed here
// S_SEP  | letter was just flushed, space or newline push is pending
// S_WRAP | line reached LINE_LEN, automatic newline push is pending
module morse_char_sequencer
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 6,
  parameter int FIFO_DEPTH  = 8,
  parameter int LINE_LEN    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          new_dot,
  input  logic                          new_dash,
  input  logic                          gap_letter,
  input  logic                          gap_word,
  input  logic                          gap_line,
  input  logic                          long_press_clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    out_kind,
  output logic [7:0]                    out_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          drop_err
);

  localparam int COL_W = $clog2(LINE_LEN + 1);
  localparam logic [COL_W-1:0] COL_END = LINE_LEN[COL_W-1:0];
  localparam logic [2:0]       LEN_MAX = MAX_SYMBOLS[2:0];

  sched_state_t            state, state_nxt;
  logic [2:0]              len;
  logic [MAX_SYMBOLS-1:0]  bits;
  logic                    ovf;
  logic [COL_W-1:0]        col, col_nxt, col_inc;
  logic                    sep_nl, sep_nl_nxt;
  logic                    flush_acc;

  logic                    push;
  cmd_kind_t               push_kind;
  logic [7:0]              push_code;
  logic [7:0]              letter_code;
  logic [9:0]              head;
  logic                    fifo_full;
  logic                    pop;

  logic [2:0]              len_b;
  logic [MAX_SYMBOLS-1:0]  bits_b;
  logic                    ovf_b;

  assign letter_code = ovf ? ASCII_UNKNOWN : morse_decode(len, MAX_SYM'(bits));
  assign col_inc     = col + 1'b1;
  assign pop         = out_valid & out_ready;

  always_comb begin
    push       = 1'b0;
    push_kind  = CMD_CHAR;
    push_code  = 8'h00;
    col_nxt    = col;
    state_nxt  = state;
    sep_nl_nxt = sep_nl;
    flush_acc  = 1'b0;
    if (long_press_clear) begin
      push      = 1'b1;
      push_kind = CMD_CLEAR;
      col_nxt   = '0;
      state_nxt = S_IDLE;
      flush_acc = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if ((gap_line || gap_word || gap_letter) && len != 3'd0) begin
            push      = 1'b1;
            push_code = letter_code;
            col_nxt   = col_inc;
            flush_acc = 1'b1;
            if (gap_line || gap_word) begin
              state_nxt  = S_SEP;
              sep_nl_nxt = gap_line;
            end else if (col_inc == COL_END) begin
              state_nxt = S_WRAP;
            end
          end else if (gap_line) begin
            push      = 1'b1;
            push_kind = CMD_NEWLINE;
            push_code = ASCII_NL;
            col_nxt   = '0;
          end else if (gap_word && col != '0) begin
            push      = 1'b1;
            push_code = ASCII_SPACE;
            col_nxt   = col_inc;
            if (col_inc == COL_END) state_nxt = S_WRAP;
          end
        end
        S_SEP: begin
          // A wrap owed by the flushed letter doubles as the word separator.
          if (sep_nl || col == COL_END) begin
            push      = 1'b1;
            push_kind = CMD_NEWLINE;
            push_code = ASCII_NL;
            col_nxt   = '0;
            state_nxt = S_IDLE;
          end else if (col == '0) begin
            state_nxt = S_IDLE;
          end else begin
            push      = 1'b1;
            push_code = ASCII_SPACE;
            col_nxt   = col_inc;
            state_nxt = (col_inc == COL_END) ? S_WRAP : S_IDLE;
          end
        end
        S_WRAP: begin
          push      = 1'b1;
          push_kind = CMD_NEWLINE;
          push_code = ASCII_NL;
          col_nxt   = '0;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // A symbol in the same cycle as a flush starts the next letter.
  always_comb begin
    len_b  = flush_acc ? 3'd0 : len;
    bits_b = flush_acc ? '0 : bits;
    ovf_b  = flush_acc ? 1'b0 : ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      col      <= '0;
      sep_nl   <= 1'b0;
      len      <= 3'd0;
      bits     <= '0;
      ovf      <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      col    <= col_nxt;
      sep_nl <= sep_nl_nxt;
      if ((new_dot || new_dash) && len_b == LEN_MAX) begin
        len  <= len_b;
        bits <= bits_b;
        ovf  <= 1'b1;
      end else if (new_dot || new_dash) begin
        len  <= len_b + 3'd1;
        bits <= {bits_b[MAX_SYMBOLS-2:0], new_dash};
        ovf  <= ovf_b;
      end else begin
        len  <= len_b;
        bits <= bits_b;
        ovf  <= ovf_b;
      end
      if (long_press_clear)
        drop_err <= 1'b0;
      else if (push && fifo_full && !pop)
        drop_err <= 1'b1;
    end
  end

  morse_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (long_press_clear),
    .push      (push),
    .push_data ({push_kind, push_code}),
    .pop       (pop),
    .head      (head),
    .valid     (out_valid),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign out_kind = out_valid ? head[9:8] : 2'd0;
  assign out_code = out_valid ? head[7:0] : 8'h00;

endmodule

// File: tb/tb_morse_char_sequencer.sv
// Directed bench for morse_char_sequencer: a table of single-cycle vectors
// followed by hand-written wrap, back-pressure, clear and reset sequences.
module tb_morse_char_sequencer;

  localparam logic [5:0] EV_NONE = 6'd0;
  localparam logic [5:0] EV_DOT  = 6'd1;
  localparam logic [5:0] EV_DASH = 6'd2;
  localparam logic [5:0] EV_GL   = 6'd4;
  localparam logic [5:0] EV_GW   = 6'd8;
  localparam logic [5:0] EV_GN   = 6'd16;
  localparam logic [5:0] EV_CLR  = 6'd32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_dot = 1'b0, new_dash = 1'b0;
  logic       gap_letter = 1'b0, gap_word = 1'b0, gap_line = 1'b0;
  logic       long_press_clear = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [1:0] out_kind;
  logic [7:0] out_code;
  logic [3:0] fifo_level;
  logic       drop_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] ev;
    logic       rdy;
    logic       v;
    logic [1:0] k;
    logic [7:0] c;
    logic [3:0] lvl;
  } vec_t;

  vec_t vecs[$];

  morse_char_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .new_dot          (new_dot),
    .new_dash         (new_dash),
    .gap_letter       (gap_letter),
    .gap_word         (gap_word),
    .gap_line         (gap_line),
    .long_press_clear (long_press_clear),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_kind         (out_kind),
    .out_code         (out_code),
    .fifo_level       (fifo_level),
    .drop_err         (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [1:0] k,
                         input logic [7:0] c, input logic [3:0] lvl);
    chk({name, ".valid"}, int'(out_valid), int'(v));
    chk({name, ".kind"},  int'(out_kind),  int'(k));
    chk({name, ".code"},  int'(out_code),  int'(c));
    chk({name, ".level"}, int'(fifo_level), int'(lvl));
  endtask

  // Drive one cycle of events; returns #1 after the edge that sampled them.
  task automatic step(input logic [5:0] ev, input logic rdy);
    new_dot          = ev[0];
    new_dash         = ev[1];
    gap_letter       = ev[2];
    gap_word         = ev[3];
    gap_line         = ev[4];
    long_press_clear = ev[5];
    out_ready        = rdy;
    @(posedge clk);
    #1;
    {new_dot, new_dash, gap_letter, gap_word, gap_line, long_press_clear} = 6'd0;
  endtask

  // Symbols are sent first-symbol-first from pat[n-1] down to pat[0].
  task automatic send(input int n, input logic [5:0] pat, input logic rdy_sym,
                      input logic rdy_gap);
    for (int j = n - 1; j >= 0; j--)
      step(pat[j] ? EV_DASH : EV_DOT, rdy_sym);
    step(EV_GL, rdy_gap);
  endtask

  task automatic add(input logic [5:0] ev, input logic rdy, input logic v,
                     input logic [1:0] k, input logic [7:0] c, input logic [3:0] lvl);
    vec_t t;
    t.ev = ev; t.rdy = rdy; t.v = v; t.k = k; t.c = c; t.lvl = lvl;
    vecs.push_back(t);
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    // "A", then "O" with word gap, then no-space word gap at column 0
    add(EV_DOT,  1, 0, 0, 8'h00, 0);
    add(EV_DASH, 1, 0, 0, 8'h00, 0);
    add(EV_GL,   1, 1, 0, 8'h41, 1);
    add(EV_NONE, 1, 0, 0, 8'h00, 0);
    add(EV_DASH, 1, 0, 0, 8'h00, 0);
    add(EV_DASH, 1, 0, 0, 8'h00, 0);
    add(EV_DASH, 1, 0, 0, 8'h00, 0);
    add(EV_GW,   1, 1, 0, 8'h4F, 1);
    add(EV_NONE, 1, 1, 0, 8'h20, 1);
    add(EV_NONE, 1, 0, 0, 8'h00, 0);
    add(EV_GN,   1, 1, 1, 8'h0A, 1);
    add(EV_NONE, 1, 0, 0, 8'h00, 0);
    add(EV_GW,   1, 0, 0, 8'h00, 0);
    add(EV_NONE, 1, 0, 0, 8'h00, 0);
    // overflow: seven dots decode to '?', next dot decodes to 'E'
    for (int i = 0; i < 7; i++) add(EV_DOT, 1, 0, 0, 8'h00, 0);
    add(EV_GL,   1, 1, 0, 8'h3F, 1);
    add(EV_DOT,  1, 0, 0, 8'h00, 0);
    add(EV_GL,   1, 1, 0, 8'h45, 1);
    add(EV_NONE, 1, 0, 0, 8'h00, 0);
    // line gap with pending letter: CHAR then NEWLINE
    add(EV_DASH, 1, 0, 0, 8'h00, 0);
    add(EV_GN,   1, 1, 0, 8'h54, 1);
    add(EV_NONE, 1, 1, 1, 8'h0A, 1);
    add(EV_NONE, 1, 0, 0, 8'h00, 0);
    // dash together with a gap starts the next letter
    add(EV_DOT,  1, 0, 0, 8'h00, 0);
    add(EV_GL | EV_DASH, 1, 1, 0, 8'h45, 1);
    add(EV_GL,   1, 1, 0, 8'h54, 1);
    add(EV_NONE, 1, 0, 0, 8'h00, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 8'h00, 0);
    chk("reset.drop_err", int'(drop_err), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].ev, vecs[i].rdy);
      chk_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].k, vecs[i].c, vecs[i].lvl);
    end

    // auto-wrap: column is 2 here, bring it back to 0 first
    step(EV_GN, 1);
    chk_out("wrap.pre_nl", 1, 1, 8'h0A, 1);
    step(EV_NONE, 1);
    for (int i = 0; i < 16; i++) begin
      step(EV_DOT, 1);
      chk($sformatf("wrap.e%0d.idle_valid", i), int'(out_valid), 0);
      step(EV_GL, 1);
      chk($sformatf("wrap.e%0d.code", i), int'(out_code), 8'h45);
    end
    step(EV_NONE, 1);
    chk_out("wrap.nl", 1, 1, 8'h0A, 1);
    step(EV_NONE, 1);
    chk_out("wrap.after", 0, 0, 8'h00, 0);
    step(EV_GW, 1);
    chk_out("wrap.col0_nospace", 0, 0, 8'h00, 0);

    // back-pressure: E T I A N M S U fill, R dropped, K pushed with a pop
    send(1, 6'b0,    0, 0);
    send(1, 6'b1,    0, 0);
    send(2, 6'b00,   0, 0);
    send(2, 6'b01,   0, 0);
    send(2, 6'b10,   0, 0);
    send(2, 6'b11,   0, 0);
    send(3, 6'b000,  0, 0);
    send(3, 6'b001,  0, 0);
    chk_out("bp.full", 1, 0, 8'h45, 8);
    chk("bp.full.drop_err", int'(drop_err), 0);
    send(3, 6'b010, 0, 0);
    chk_out("bp.drop", 1, 0, 8'h45, 8);
    chk("bp.drop.drop_err", int'(drop_err), 1);
    send(3, 6'b101, 0, 1);
    chk_out("bp.push_pop", 1, 0, 8'h54, 8);
    drain_exp[0] = 8'h54; drain_exp[1] = 8'h49; drain_exp[2] = 8'h41;
    drain_exp[3] = 8'h4E; drain_exp[4] = 8'h4D; drain_exp[5] = 8'h53;
    drain_exp[6] = 8'h55; drain_exp[7] = 8'h4B;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("bp.drain%0d", i), 1, 0, drain_exp[i], 4'(8 - i));
      step(EV_NONE, 1);
    end
    chk_out("bp.empty", 0, 0, 8'h00, 0);
    chk("bp.drop_sticky", int'(drop_err), 1);

    // clear with 5 queued entries and a partial pattern
    for (int i = 0; i < 5; i++) send(1, 6'b0, 0, 0);
    chk("clr.pre_level", int'(fifo_level), 5);
    step(EV_DOT, 0);
    step(EV_CLR, 0);
    chk_out("clr.head", 1, 2, 8'h00, 1);
    chk("clr.drop_err", int'(drop_err), 0);
    step(EV_GL, 0);
    chk_out("clr.acc_empty", 1, 2, 8'h00, 1);
    step(EV_NONE, 1);
    chk_out("clr.popped", 0, 0, 8'h00, 0);
    step(EV_GW, 1);
    chk_out("clr.col0", 0, 0, 8'h00, 0);

    // reset mid-operation discards queued entries
    send(1, 6'b0, 0, 0);
    send(1, 6'b1, 0, 0);
    chk("rst_mid.pre_level", int'(fifo_level), 2);
    rst = 1'b1;
    step(EV_NONE, 0);
    chk_out("rst_mid", 0, 0, 8'h00, 0);
    rst = 1'b0;
    send(2, 6'b01, 1, 1);
    chk_out("rst_mid.after", 1, 0, 8'h41, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_char_sequencer.md
# morse_char_sequencer

Sequences the pulse events from the Morse pulse classifier (dot, dash, letter/word/line gap, long-press clear) into a stream of display commands.
- Accumulates the dot/dash pattern of the current letter.
- Decodes the letter to ASCII on a gap.
- Schedules separator, auto-wrap and clear commands.
- Buffers everything in a small FIFO drained by the display writer over a valid/ready handshake.

It sits between the pulse classifier and the LCD/UART writer.

## Interface
- `MAX_SYMBOLS`, 6: longest accepted pattern; longer patterns decode to `'?'`.
- `FIFO_DEPTH`, 8: command FIFO entries, power of two.
- `LINE_LEN`, 16: printable columns per line before an automatic NEWLINE.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `new_dot`, `new_dash` in 1: single-cycle symbol pulses.
- `gap_letter`, `gap_word`, `gap_line` in 1: single-cycle gap pulses.
- `long_press_clear` in 1: single-cycle clear pulse.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head this cycle.
- `out_kind` out 2: command at the head. CHAR=0, NEWLINE=1, CLEAR=2.
- `out_code` out 8: ASCII for CHAR; 0x0A for NEWLINE; 0x00 for CLEAR.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `drop_err` out 1: sticky flag, set when a push hits a full FIFO.

## Operation
- **Accumulator:** 3-bit `len` plus `MAX_SYMBOLS`-bit `bits`. A dot appends 0 and a dash appends 1 at the LSB, with the earlier symbol ending up more significant.
  - If `len==MAX_SYMBOLS`, further symbols set `ovf` instead of shifting.
- **Decode:** a pure function of (`len`, `bits`, `ovf`). Covers A–Z and 0–9 in ITU patterns. Unknown or `ovf` decodes to 0x3F.
  - Examples: E=(1,0) gives 0x45; A=(2,01) gives 0x41; 0=(5,11111) gives 0x30.
- **Event priority within one cycle:** clear > line > word > letter. A dot or dash arriving in the same cycle as a gap becomes the first symbol of the next letter.
- **gap_letter:** if `len>0`, push CHAR and reset the accumulator. If `len==0`, do nothing.
- **gap_word:** flush the pending letter as above, then push CHAR 0x20 one cycle later. The space is suppressed when `col==0`.
- **gap_line:** flush the pending letter, then push NEWLINE one cycle later.
- **Column counter `col`:** increments on each CHAR push and resets to 0 on a NEWLINE push. When a CHAR push brings `col` to `LINE_LEN`, push NEWLINE on the next cycle.
- **long_press_clear:** empty the FIFO, clear the accumulator, set `col=0`, clear `drop_err`, push CLEAR, and return to S_IDLE. Takes effect in any state.
- **Scheduler FSM:**
  - States: S_IDLE, S_SEP (pending space/newline push), S_WRAP (pending auto-NEWLINE).
  - S_IDLE → S_SEP on word/line gap with a letter to flush; otherwise push the separator directly and stay.
  - S_SEP pushes its separator, then goes to S_WRAP if a wrap is owed, else S_IDLE.
  - S_WRAP pushes NEWLINE → S_IDLE.
  - A CHAR push that lands in S_WRAP's cycle cannot occur, because gaps in S_SEP/S_WRAP are ignored. Dots and dashes in those states are still accumulated.
- **FIFO:** first-word-fall-through. A pop occurs when `out_valid & out_ready`.
  - Push while full with no pop: the entry is dropped and `drop_err` is set to 1.
  - Push while full with a simultaneous pop: the push is accepted and `fifo_level` is unchanged.

## Timing
- **Reset:** all outputs 0 (`out_valid`, `out_kind`, `out_code`, `fifo_level`, `drop_err`). Accumulator, `col` and pointers cleared; state S_IDLE.
- **Reset mid-operation:** the FIFO contents are discarded.
- `out_kind` and `out_code` are forced to 0 whenever `out_valid==0`.
- **Latency:**
  - A gap pulse at cycle N writes the CHAR at the N edge; `out_valid` rises at N+1 if the FIFO was empty.
  - The separator is visible at N+2.
  - The auto-wrap NEWLINE follows the triggering push by exactly 1 cycle.
- **Clear:** at cycle N, `fifo_level` reads 1 and the head reads CLEAR at N+1. Entries popped in cycle N are still consumed normally.
- **Handshake:** `out_kind` and `out_code` are stable while `out_valid & ~out_ready`. `out_valid` never drops without a pop or a clear.
- **Pointer wrap:** the read and write pointers wrap modulo `FIFO_DEPTH`; the extra MSB distinguishes full from empty.

## Structure
- **`morse_pkg`** holds:
  - the `cmd_kind_t` enum (CHAR, NEWLINE, CLEAR);
  - constants `ASCII_SPACE`, `ASCII_NL`, `ASCII_UNKNOWN`;
  - the `morse_decode(len, bits)` function.
- **`morse_cmd_fifo`** (sub-module): a parameterised FWFT FIFO with a 10-bit entry (kind + code), `push`/`pop`/`full`/`level`, and a synchronous flush.
- The top level contains the accumulator, the scheduler FSM, `col` and `drop_err`.

## Test plan
- **Single letter:** dot, dash, then gap_letter with `out_ready=1` → one CHAR 0x41. `out_valid` rises 1 cycle after the gap.
- **Word gap:** dash, dash, dash, gap_word → CHAR 0x4F at N+1, CHAR 0x20 at N+2. A gap_word with `col==0` → no space.
- **Overflow:** 7 dots, then gap_letter → CHAR 0x3F. `len` resets, and the next single dot decodes to 0x45.
- **Auto-wrap:** `LINE_LEN`=16 letters "E" → after the 16th CHAR, NEWLINE 0x0A appears 1 cycle later and `col` reads 0.
- **Back-pressure:** hold `out_ready=0` and push 9 letters → `fifo_level`=8, `drop_err`=1, and the first 8 letters are delivered in order. A push together with a pop while full → `fifo_level` stays 8.
- **Clear:** with 5 entries queued and a partial pattern pending, assert long_press_clear → next cycle `fifo_level`=1, head is CLEAR with code 0x00, and `drop_err`=0.
